// File: rtl/dcache_victim_buffer.sv
// Fully associative victim buffer beside the write-back dcache: holds displaced lines,
// serves swaps, evicts dirty lines round-robin through a wb valid/ready port, supports flush.
module dcache_victim_buffer #(
  parameter int ENTRIES    = 4,
  parameter int LINE_WIDTH = 128,
  parameter int LADDR_BITS = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LADDR_BITS-1:0]         lookup_laddr_i,
  output logic                          hit_o,
  output logic [LINE_WIDTH-1:0]         hit_data_o,
  output logic                          hit_dirty_o,
  input  logic                          extract_i,
  input  logic                          insert_valid_i,
  output logic                          insert_ready_o,
  input  logic [LADDR_BITS-1:0]         insert_laddr_i,
  input  logic [LINE_WIDTH-1:0]         insert_data_i,
  input  logic                          insert_dirty_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [LADDR_BITS-1:0]         wb_laddr_o,
  output logic [LINE_WIDTH-1:0]         wb_data_o,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic [$clog2(ENTRIES+1)-1:0]  occupancy_o
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WB_EVICT   = 2'd1;
  localparam logic [1:0] S_FLUSH_SCAN = 2'd2;
  localparam logic [1:0] S_FLUSH_WB   = 2'd3;

  logic [ENTRIES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [LADDR_BITS-1:0] laddr_q [ENTRIES];
  logic [LADDR_BITS-1:0] laddr_d [ENTRIES];
  logic [LINE_WIDTH-1:0] data_q  [ENTRIES];
  logic [LINE_WIDTH-1:0] data_d  [ENTRIES];
  logic [IDX_W-1:0]      victim_ptr_q, victim_ptr_d, scan_idx_q, scan_idx_d;
  logic [1:0]            state_q, state_d;
  logic                  wb_valid_q, wb_valid_d, flush_done_q, flush_done_d;
  logic [LADDR_BITS-1:0] wb_laddr_q, wb_laddr_d;
  logic [LINE_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [OCC_W-1:0]      occupancy_q, occupancy_d;

  logic             hit_any, dup_any, free_any, is_idle, do_extract, do_insert, dup_live;
  logic [IDX_W-1:0] hit_idx, dup_idx, free_idx, ins_idx;

  // Two address comparators per entry: one for the lookup probe, one to detect duplicate inserts.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    dup_any  = 1'b0;
    dup_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && laddr_q[i] == lookup_laddr_i) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (valid_q[i] && laddr_q[i] == insert_laddr_i) begin
        dup_any = 1'b1;
        dup_idx = IDX_W'(i);
      end
      if (!valid_q[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign is_idle        = (state_q == S_IDLE);
  assign hit_o          = is_idle && hit_any;
  assign hit_data_o     = hit_o ? data_q[hit_idx] : '0;
  assign hit_dirty_o    = hit_o && dirty_q[hit_idx];
  assign do_extract     = hit_o && extract_i && !flush_i;
  // With no free slot the buffer is full, so only the victim's dirty bit remains to check.
  assign insert_ready_o = is_idle && !flush_i &&
                          (free_any || do_extract || !dirty_q[victim_ptr_q]);
  assign do_insert      = insert_valid_i && insert_ready_o;
  assign dup_live       = dup_any && !(do_extract && dup_idx == hit_idx);

  always_comb begin
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    laddr_d      = laddr_q;
    data_d       = data_q;
    victim_ptr_d = victim_ptr_q;
    scan_idx_d   = scan_idx_q;
    state_d      = state_q;
    wb_valid_d   = wb_valid_q;
    wb_laddr_d   = wb_laddr_q;
    wb_data_d    = wb_data_q;
    flush_done_d = 1'b0;
    ins_idx      = '0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d    = S_FLUSH_SCAN;
          scan_idx_d = '0;
        end else begin
          if (do_extract) valid_d[hit_idx] = 1'b0;
          if (do_insert) begin
            if (dup_live) begin
              dirty_d[dup_idx] = dirty_q[dup_idx] | insert_dirty_i;
              data_d[dup_idx]  = insert_data_i;
            end else begin
              if (do_extract)    ins_idx = hit_idx;
              else if (free_any) ins_idx = free_idx;
              else begin
                ins_idx      = victim_ptr_q;
                victim_ptr_d = victim_ptr_q + IDX_W'(1);
              end
              valid_d[ins_idx] = 1'b1;
              dirty_d[ins_idx] = insert_dirty_i;
              laddr_d[ins_idx] = insert_laddr_i;
              data_d[ins_idx]  = insert_data_i;
            end
          end else if (insert_valid_i) begin
            state_d    = S_WB_EVICT;
            wb_valid_d = 1'b1;
            wb_laddr_d = laddr_q[victim_ptr_q];
            wb_data_d  = data_q[victim_ptr_q];
          end
        end
      end
      S_WB_EVICT: begin
        if (wb_ready_i) begin
          wb_valid_d            = 1'b0;
          valid_d[victim_ptr_q] = 1'b0;
          dirty_d[victim_ptr_q] = 1'b0;
          victim_ptr_d          = victim_ptr_q + IDX_W'(1);
          state_d               = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        if (valid_q[scan_idx_q] && dirty_q[scan_idx_q]) begin
          state_d    = S_FLUSH_WB;
          wb_valid_d = 1'b1;
          wb_laddr_d = laddr_q[scan_idx_q];
          wb_data_d  = data_q[scan_idx_q];
        end else if (scan_idx_q == LAST_IDX) begin
          valid_d      = '0;
          dirty_d      = '0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      default: begin
        if (wb_ready_i) begin
          wb_valid_d          = 1'b0;
          dirty_d[scan_idx_q] = 1'b0;
          if (scan_idx_q == LAST_IDX) begin
            valid_d      = '0;
            dirty_d      = '0;
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
            state_d    = S_FLUSH_SCAN;
          end
        end
      end
    endcase
  end

  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < ENTRIES; i++) occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_ptr_q <= '0;
      scan_idx_q   <= '0;
      state_q      <= S_IDLE;
      wb_valid_q   <= 1'b0;
      wb_laddr_q   <= '0;
      wb_data_q    <= '0;
      flush_done_q <= 1'b0;
      occupancy_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      victim_ptr_q <= victim_ptr_d;
      scan_idx_q   <= scan_idx_d;
      state_q      <= state_d;
      wb_valid_q   <= wb_valid_d;
      wb_laddr_q   <= wb_laddr_d;
      wb_data_q    <= wb_data_d;
      flush_done_q <= flush_done_d;
      occupancy_q  <= occupancy_d;
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    laddr_q <= laddr_d;
    data_q  <= data_d;
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_laddr_o   = wb_laddr_q;
  assign wb_data_o    = wb_data_q;
  assign flush_done_o = flush_done_q;
  assign occupancy_o  = occupancy_q;
endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Directed bench for dcache_victim_buffer: insert/lookup, clean and dirty replacement,
// swap, duplicate merge, flush ordering and reset during flush.
module tb_dcache_victim_buffer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [27:0]  lookup_laddr_i;
  logic         hit_o;
  logic [127:0] hit_data_o;
  logic         hit_dirty_o;
  logic         extract_i;
  logic         insert_valid_i;
  logic         insert_ready_o;
  logic [27:0]  insert_laddr_i;
  logic [127:0] insert_data_i;
  logic         insert_dirty_i;
  logic         wb_valid_o;
  logic         wb_ready_i;
  logic [27:0]  wb_laddr_o;
  logic [127:0] wb_data_o;
  logic         flush_i;
  logic         flush_done_o;
  logic [2:0]   occupancy_o;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] DAT_AA = {16{8'hAA}};
  localparam logic [127:0] DAT_55 = {16{8'h55}};

  dcache_victim_buffer #(.ENTRIES(4), .LINE_WIDTH(128), .LADDR_BITS(28)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_laddr_i(lookup_laddr_i), .hit_o(hit_o), .hit_data_o(hit_data_o),
    .hit_dirty_o(hit_dirty_o), .extract_i(extract_i),
    .insert_valid_i(insert_valid_i), .insert_ready_o(insert_ready_o),
    .insert_laddr_i(insert_laddr_i), .insert_data_i(insert_data_i),
    .insert_dirty_i(insert_dirty_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_laddr_o(wb_laddr_o),
    .wb_data_o(wb_data_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [27:0] a);
    return {4{4'h0, a}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lookup_laddr_i = '0;
    extract_i      = 1'b0;
    insert_valid_i = 1'b0;
    insert_laddr_i = '0;
    insert_data_i  = '0;
    insert_dirty_i = 1'b0;
    wb_ready_i     = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ins(input logic [27:0] a, input logic [127:0] d, input logic dirty);
    insert_valid_i = 1'b1;
    insert_laddr_i = a;
    insert_data_i  = d;
    insert_dirty_i = dirty;
    tick();
    insert_valid_i = 1'b0;
  endtask

  task automatic look(input logic [27:0] a);
    lookup_laddr_i = a;
    #1;
  endtask

  task automatic fill_1_3_dirty();
    for (int i = 0; i < 4; i++) ins(28'h100 + 28'(i), mk(28'h100 + 28'(i)), (i == 1 || i == 3));
  endtask

  initial begin
    int          n_wb;
    int          n_done;
    logic [27:0] wb_addr [2];
    logic        found;

    // Reset state and basic insert/lookup
    do_reset();
    chk("rst_occ", occupancy_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_rdy", insert_ready_o, 1);
    ins(28'h0000010, DAT_AA, 1'b0);
    chk("ins_occ", occupancy_o, 1);
    look(28'h0000010);
    chk("lk_hit", hit_o, 1);
    chk("lk_data", hit_data_o, DAT_AA);
    look(28'h0000011);
    chk("lk_miss", hit_o, 0);
    chk("lk_miss_data", hit_data_o, 0);

    // Full of clean lines: round-robin replacement without writeback
    do_reset();
    for (int i = 0; i < 4; i++) ins(28'h100 + 28'(i), mk(28'h100 + 28'(i)), 1'b0);
    chk("full_occ", occupancy_o, 4);
    insert_valid_i = 1'b1;
    insert_laddr_i = 28'h200;
    insert_data_i  = mk(28'h200);
    insert_dirty_i = 1'b0;
    #1;
    chk("clean_rdy", insert_ready_o, 1);
    tick();
    insert_valid_i = 1'b0;
    chk("clean_wbv", wb_valid_o, 0);
    chk("clean_occ", occupancy_o, 4);
    look(28'h100);
    chk("clean_e0_gone", hit_o, 0);
    look(28'h200);
    chk("clean_e_hit", hit_o, 1);
    ins(28'h201, mk(28'h201), 1'b0);
    look(28'h101);
    chk("ptr1_e1_gone", hit_o, 0);
    look(28'h102);
    chk("ptr1_e2_kept", hit_o, 1);

    // Full with dirty victim: writeback held off by wb_ready_i
    do_reset();
    for (int i = 0; i < 4; i++) ins(28'h100 + 28'(i), mk(28'h100 + 28'(i)), (i == 0));
    insert_valid_i = 1'b1;
    insert_laddr_i = 28'h200;
    insert_data_i  = mk(28'h200);
    insert_dirty_i = 1'b0;
    #1;
    chk("dv_rdy0", insert_ready_o, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("dv_hold_rdy", insert_ready_o, 0);
      chk("dv_hold_wbv", wb_valid_o, 1);
      chk("dv_hold_addr", wb_laddr_o, 28'h100);
      chk("dv_hold_data", wb_data_o, mk(28'h100));
      tick();
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("dv_wbv_low", wb_valid_o, 0);
    chk("dv_occ3", occupancy_o, 3);
    chk("dv_rdy1", insert_ready_o, 1);
    tick();
    insert_valid_i = 1'b0;
    chk("dv_occ4", occupancy_o, 4);
    look(28'h200);
    chk("dv_e_hit", hit_o, 1);
    chk("dv_e_clean", hit_dirty_o, 0);
    look(28'h100);
    chk("dv_old_gone", hit_o, 0);

    // Swap: extract B and insert C in one cycle
    lookup_laddr_i = 28'h102;
    extract_i      = 1'b1;
    insert_valid_i = 1'b1;
    insert_laddr_i = 28'h300;
    insert_data_i  = mk(28'h300);
    insert_dirty_i = 1'b0;
    #1;
    chk("sw_hit", hit_o, 1);
    chk("sw_rdy", insert_ready_o, 1);
    tick();
    extract_i      = 1'b0;
    insert_valid_i = 1'b0;
    chk("sw_occ", occupancy_o, 4);
    chk("sw_wbv", wb_valid_o, 0);
    look(28'h102);
    chk("sw_b_gone", hit_o, 0);
    look(28'h300);
    chk("sw_c_hit", hit_o, 1);
    chk("sw_c_data", hit_data_o, mk(28'h300));

    // Extract without insert
    look(28'h103);
    extract_i = 1'b1;
    tick();
    extract_i = 1'b0;
    chk("ext_occ", occupancy_o, 3);

    // Duplicate insert merges dirty and overwrites data
    do_reset();
    ins(28'h0000010, DAT_AA, 1'b0);
    ins(28'h0000010, DAT_55, 1'b1);
    chk("dup_occ", occupancy_o, 1);
    look(28'h0000010);
    chk("dup_dirty", hit_dirty_o, 1);
    chk("dup_data", hit_data_o, DAT_55);

    // Flush with entries 1 and 3 dirty
    do_reset();
    fill_1_3_dirty();
    wb_ready_i = 1'b1;
    flush_i    = 1'b1;
    tick();
    flush_i = 1'b0;
    n_wb    = 0;
    n_done  = 0;
    for (int c = 0; c < 30; c++) begin
      if (wb_valid_o) begin
        if (n_wb < 2) wb_addr[n_wb] = wb_laddr_o;
        n_wb++;
      end
      if (flush_done_o) n_done++;
      tick();
    end
    chk("fl_nwb", n_wb, 2);
    chk("fl_wb0", wb_addr[0], 28'h101);
    chk("fl_wb1", wb_addr[1], 28'h103);
    chk("fl_done", n_done, 1);
    chk("fl_occ", occupancy_o, 0);
    look(28'h101);
    chk("fl_miss", hit_o, 0);

    // Repeat flush, reset during the second writeback
    wb_ready_i = 1'b0;
    fill_1_3_dirty();
    chk("fl2_occ", occupancy_o, 4);
    wb_ready_i = 1'b1;
    flush_i    = 1'b1;
    tick();
    flush_i = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (wb_valid_o && wb_laddr_o == 28'h103) begin
        found = 1'b1;
        rst_n = 1'b0;
        break;
      end
      tick();
    end
    chk("fl2_reached", found, 1);
    tick();
    wb_ready_i = 1'b0;
    chk("fl2_rst_wbv", wb_valid_o, 0);
    chk("fl2_rst_occ", occupancy_o, 0);
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (flush_done_o) n_done++;
      tick();
    end
    chk("fl2_no_done", n_done, 0);
    chk("fl2_rdy", insert_ready_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
